serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operands a, b, bin valid.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  minuend, unsigned.
REQ-007 Port: b  input  WIDTH  subtrahend, unsigned.
REQ-008 Port: bin  input  1  borrow-in, for chaining.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: diff  output  WIDTH  result, a - b - bin modulo 2^WIDTH.
REQ-012 Port: bout  output  1  final borrow-out.
REQ-013 Port: busy  output  1  high in SHIFT or DONE.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 in_ready shall be 1 only in IDLE; out_valid shall be 1 only in DONE.
REQ-016 Input handshake: in_valid & in_ready at an edge latches a, b and bin into internal registers, clears the bit counter, and moves to SHIFT.
REQ-017 SHIFT: one bit per cycle, LSB first, through a 1-bit full-subtractor cell: d = x^y^br, next br = (~x&y) | (~(x^y)&br), where br is a borrow flip-flop initialised from bin.
REQ-018 Each SHIFT cycle writes d into diff bit position [count], or equivalently shifts d into the MSB of a result shift register.
REQ-019 SHIFT lasts exactly WIDTH cycles; after the last bit, the FSM moves to DONE and bout takes the final borrow.
REQ-020 Latency: out_valid rises exactly WIDTH+1 edges after the accepting edge (for WIDTH=8: 9 cycles).
REQ-021 DONE: diff, bout and out_valid hold stable until out_valid & out_ready; at that edge the FSM moves to IDLE.
REQ-022 No new operand is accepted in the same cycle as the result handshake; throughput is one operation per WIDTH+2 cycles minimum.
REQ-023 in_valid while not in IDLE is ignored; a, b and bin may change freely after acceptance without affecting the result.
REQ-024 Result: bout = 1 iff a < b + bin, unsigned compare; diff equals (a - b - bin) mod 2^WIDTH for all inputs, including a=b and bin=1 on zero operands.
REQ-025 diff and bout are don't-care outside DONE, but shall hold registered values; they are not combinational from the inputs.

Reset
REQ-026 While rst=1 at an edge: FSM to IDLE; in_ready=1; out_valid=0; busy=0; diff=0; bout=0; counter and borrow flip-flop cleared.
REQ-027 Reset asserted mid-SHIFT or in DONE shall abort the operation with no result handshake; the next operation after reset is fully correct.
REQ-028 rst has priority over every handshake in the same cycle.

Configuration
REQ-029 Macro SERIAL_SUBTRACTOR_OVF_EN: when defined, add output port ovf (1 bit) giving signed two's-complement overflow of a - b - bin, registered with bout.
REQ-030 Rule when defined: ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]); it is reset to 0 and is stable in DONE.
REQ-031 When the macro is not defined, port ovf and its logic shall be absent; all other behaviour is identical.

Verification
REQ-032 WIDTH=8, a=5, b=3, bin=0 accepted at cycle T -> out_valid at T+9, diff=0x02, bout=0.
REQ-033 a=3, b=5, bin=0 -> diff=0xFE, bout=1; a=0, b=0, bin=1 -> diff=0xFF, bout=1.
REQ-034 Backpressure: result ready with out_ready=0 for 5 cycles -> diff, bout and out_valid unchanged, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-035 rst pulse at the 4th SHIFT cycle -> next cycle IDLE with all outputs at reset values; a following a=0xAA, b=0x55 operation -> diff=0x55, bout=0.
REQ-036 With SERIAL_SUBTRACTOR_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0; a=0x10, b=0x01 -> ovf=0.
REQ-037 Random a/b/bin (at least 1000 cases, random out_ready stalls) -> diff and bout match the reference model, and latency is always WIDTH+1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per cycle, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic               w_busy_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic [CNT_W-1:0]   r_count;
    logic               r_br;
    logic               r_bout;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_x;
    logic               w_y;
    logic               w_d;
    logic               w_br_nxt;
    logic               w_last;
    logic               w_accept;

    // Full-subtractor cell on the current LSBs
    assign w_x      = r_a[0];
    assign w_y      = r_b[0];
    assign w_d      = w_x ^ w_y ^ r_br;
    assign w_br_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    assign w_last   = (r_count == CNT_W'(WIDTH - 1));
    assign w_accept = in_valid && (r_state == S_IDLE);

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    // State and handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Operand shift registers, borrow chain and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_diff  <= '0;
            r_count <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_count <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_br    <= w_br_nxt;
                    r_diff  <= {w_d, r_diff[WIDTH-1:1]};
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) r_bout <= w_br_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Operand sign bits are kept aside since the operand registers shift away
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            if (r_state == S_SHIFT && w_last) begin
                r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign diff      = r_diff;
    assign bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: random operands and stalls against an arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned WIDTH   = 8;
    localparam int          N_RAND  = 1000;
    localparam int          N_DIR   = 8;
    localparam int          N_OPS   = N_RAND + N_DIR;
    localparam int          LATENCY = WIDTH + 1;
    localparam int          MAX_CYC = 60000;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_issued = 0;
    int   n_done   = 0;
    bit   en       = 0;

    logic [WIDTH-1:0] dir_a [N_DIR] = '{8'h05, 8'h03, 8'h00, 8'hAA, 8'h80, 8'h10, 8'hFF, 8'h00};
    logic [WIDTH-1:0] dir_b [N_DIR] = '{8'h03, 8'h05, 8'h00, 8'h55, 8'h01, 8'h01, 8'hFF, 8'hFF};
    logic             dir_c [N_DIR] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic on the operands
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mc, input int at);
        exp_t e;
        int   ai;
        int   bi;
        int   ci;
        ai    = int'(ma);
        bi    = int'(mb);
        ci    = int'(mc);
        e.d   = WIDTH'((ai - bi - ci) & ((1 << WIDTH) - 1));
        e.bo  = (ai < bi + ci);
        e.ov  = (ma[WIDTH-1] != mb[WIDTH-1]) && (e.d[WIDTH-1] != ma[WIDTH-1]);
        e.cyc = at;
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  longint'(in_ready),  1);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_busy"},      longint'(busy),      0);
        check({tag, "_diff"},      longint'(diff),      0);
        check({tag, "_bout"},      longint'(bout),      0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check({tag, "_ovf"},       longint'(ovf),       0);
`endif
    endtask

    // Driver: offers operands whenever idle, toggles garbage while busy
    initial begin
        forever begin
            @(negedge clk);
            if (en) begin
                if (in_ready && n_issued < N_OPS) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    if (n_issued < N_DIR) begin
                        a   = dir_a[n_issued];
                        b   = dir_b[n_issued];
                        bin = dir_c[n_issued];
                    end else begin
                        a   = WIDTH'($urandom);
                        b   = WIDTH'($urandom);
                        bin = 1'($urandom);
                    end
                    if (in_valid) begin
                        q.push_back(model(a, b, bin, cyc));
                        n_issued++;
                    end
                end else begin
                    in_valid = 1'($urandom);
                    a        = WIDTH'($urandom);
                    b        = WIDTH'($urandom);
                    bin      = 1'($urandom);
                end
            end
        end
    end

    // Monitor: pops the expected result when a new result appears, checks hold under stall
    initial begin
        exp_t             cur;
        logic             prev_ov = 1'b0;
        int               stall   = 0;
        logic [WIDTH-1:0] hold_d  = '0;
        logic             hold_b  = 1'b0;
        forever begin
            @(negedge clk);
            if (en) begin
                check("busy_vs_ready", longint'(busy), longint'(!in_ready));
                if (out_valid) begin
                    if (!prev_ov) begin
                        if (q.size() == 0) begin
                            check("unexpected_result", 1, 0);
                        end else begin
                            cur = q.pop_front();
                            check("diff", longint'(diff), longint'(cur.d));
                            check("bout", longint'(bout), longint'(cur.bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                            check("ovf", longint'(ovf), longint'(cur.ov));
`endif
                            check("latency", longint'(cyc - cur.cyc), longint'(LATENCY));
                        end
                        hold_d = diff;
                        hold_b = bout;
                        stall  = (n_done == 0) ? 5 : $urandom_range(0, 3);
                    end else begin
                        check("hold_diff", longint'(diff), longint'(hold_d));
                        check("hold_bout", longint'(bout), longint'(hold_b));
                    end
                    check("ready_in_done", longint'(in_ready), 0);
                    if (stall > 0) begin
                        out_ready = 1'b0;
                        stall--;
                    end else begin
                        out_ready = 1'b1;
                        n_done++;
                    end
                end else begin
                    if (prev_ov) check("idle_after_release", longint'(in_ready), 1);
                    out_ready = 1'($urandom);
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Abort an operation with reset during its 4th shift cycle
        @(negedge clk);
        a        = 8'h12;
        b        = 8'h34;
        bin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("shift_busy",  longint'(busy),     1);
        check("shift_ready", longint'(in_ready), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort");
        @(negedge clk);
        check("abort_stays_idle", longint'(out_valid), 0);

        en = 1;
        while (n_done < N_OPS && cyc < MAX_CYC) @(negedge clk);
        if (n_done < N_OPS) check("timeout_ops_done", longint'(n_done), longint'(N_OPS));
        repeat (3) @(negedge clk);
        en = 0;
        check("scoreboard_empty", longint'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
